// File: rtl/sec_countdown.sv
// Loadable BCD mm:ss countdown timer with idle/run/pause/expired control and a one-cycle TimeUp.
// Optional low-time warning output is enabled by defining SEC_COUNTDOWN_WARN_EN.
module sec_countdown #(
   parameter int unsigned WARN_SECS = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [15:0] load_time,
   input  logic        start,
   input  logic        pause,
   input  logic        OneSecTimeout,
   output logic [15:0] time_bcd,
   output logic        running,
`ifdef SEC_COUNTDOWN_WARN_EN
   output logic        TimeUp,
   output logic        warn
`else
   output logic        TimeUp
`endif
);

   typedef enum logic [1:0] {StIdle, StRun, StPause, StExpired} state_t;

   state_t      stateQ, stateD;
   logic [15:0] timeQ, timeD;
   logic        runningQ, timeUpQ, timeUpD;

   function automatic logic [15:0] sanitise(input logic [15:0] t);
      logic [3:0] mt, mo, st, so;
      mt = (t[15:12] > 4'd9) ? 4'd9 : t[15:12];
      mo = (t[11:8]  > 4'd9) ? 4'd9 : t[11:8];
      st = (t[7:4]   > 4'd5) ? 4'd5 : t[7:4];
      so = (t[3:0]   > 4'd9) ? 4'd9 : t[3:0];
      return {mt, mo, st, so};
   endfunction

   // Only called with a non-zero time, so the minute-tens borrow never wraps.
   function automatic logic [15:0] decrement(input logic [15:0] t);
      logic [3:0] mt, mo, st, so;
      {mt, mo, st, so} = t;
      if (so != 4'd0) begin
         so = so - 4'd1;
      end else begin
         so = 4'd9;
         if (st != 4'd0) begin
            st = st - 4'd1;
         end else begin
            st = 4'd5;
            if (mo != 4'd0) begin
               mo = mo - 4'd1;
            end else begin
               mo = 4'd9;
               mt = mt - 4'd1;
            end
         end
      end
      return {mt, mo, st, so};
   endfunction

   always_comb begin
      stateD  = stateQ;
      timeD   = timeQ;
      timeUpD = 1'b0;
      if (load) begin
         timeD  = sanitise(load_time);
         stateD = StIdle;
      end else begin
         unique case (stateQ)
            StIdle: begin
               if (!pause && start) begin
                  if (timeQ == 16'h0000) begin
                     stateD  = StExpired;
                     timeUpD = 1'b1;
                  end else begin
                     stateD = StRun;
                  end
               end
            end
            StRun: begin
               if (pause) begin
                  stateD = StPause;
               end else if (OneSecTimeout) begin
                  timeD = decrement(timeQ);
                  if (timeD == 16'h0000) begin
                     stateD  = StExpired;
                     timeUpD = 1'b1;
                  end
               end
            end
            StPause: begin
               if (!pause && start) stateD = StRun;
            end
            StExpired: begin
               timeD = 16'h0000;
            end
            default: stateD = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stateQ   <= StIdle;
         timeQ    <= 16'h0000;
         runningQ <= 1'b0;
         timeUpQ  <= 1'b0;
      end else begin
         stateQ   <= stateD;
         timeQ    <= timeD;
         runningQ <= (stateD == StRun);
         timeUpQ  <= timeUpD;
      end
   end

`ifdef SEC_COUNTDOWN_WARN_EN
   localparam logic [6:0] WarnThresh = 7'(WARN_SECS);

   logic       warnQ, warnD;
   logic [6:0] secsD;

   // Threshold is below one minute, so any non-zero minutes digit disables the warning.
   always_comb begin
      secsD = 7'(timeD[7:4]) * 7'd10 + 7'(timeD[3:0]);
      warnD = ((stateD == StRun) || (stateD == StPause)) && (timeD[15:8] == 8'h00) &&
              (secsD != 7'd0) && (secsD <= WarnThresh);
   end

   always_ff @(posedge clk) begin
      if (rst) warnQ <= 1'b0;
      else     warnQ <= warnD;
   end

   assign warn = warnQ;
`endif

   assign time_bcd = timeQ;
   assign running  = runningQ;
   assign TimeUp   = timeUpQ;

endmodule

// File: tb/tb_sec_countdown.sv
// Self-checking bench for sec_countdown: directed scenarios plus random stimulus against
// a model that tracks remaining time as plain integer seconds.
module tb_sec_countdown;

   localparam int unsigned WarnSecs = 10;

   logic        clk = 1'b0;
   logic        rst, load, start, pause, OneSecTimeout;
   logic [15:0] load_time;
   logic [15:0] time_bcd;
   logic        running, TimeUp;
`ifdef SEC_COUNTDOWN_WARN_EN
   logic        warn;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model state
   int remSecs = 0;
   bit mRun = 0, mPause = 0, mExp = 0, mTimeUp = 0;

   sec_countdown #(.WARN_SECS(WarnSecs)) dut (
      .clk          (clk),
      .rst          (rst),
      .load         (load),
      .load_time    (load_time),
      .start        (start),
      .pause        (pause),
      .OneSecTimeout(OneSecTimeout),
      .time_bcd     (time_bcd),
      .running      (running),
`ifdef SEC_COUNTDOWN_WARN_EN
      .TimeUp       (TimeUp),
      .warn         (warn)
`else
      .TimeUp       (TimeUp)
`endif
   );

   always #5 clk = ~clk;

   task automatic checkEq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int clampDigit(input int d, input int maxVal);
      return (d > maxVal) ? maxVal : d;
   endfunction

   function automatic int loadSeconds(input logic [15:0] t);
      int mt, mo, st, so;
      mt = clampDigit(int'(t[15:12]), 9);
      mo = clampDigit(int'(t[11:8]), 9);
      st = clampDigit(int'(t[7:4]), 5);
      so = clampDigit(int'(t[3:0]), 9);
      return (mt * 10 + mo) * 60 + st * 10 + so;
   endfunction

   function automatic logic [15:0] toBcd(input int secs);
      int m, s;
      m = secs / 60;
      s = secs % 60;
      return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   task automatic modelStep(input bit r, input bit l, input logic [15:0] lt,
                            input bit s, input bit p, input bit t);
      mTimeUp = 0;
      if (r) begin
         remSecs = 0; mRun = 0; mPause = 0; mExp = 0;
      end else if (l) begin
         remSecs = loadSeconds(lt); mRun = 0; mPause = 0; mExp = 0;
      end else if (mRun) begin
         if (p) begin
            mRun = 0; mPause = 1;
         end else if (t) begin
            remSecs--;
            if (remSecs == 0) begin
               mRun = 0; mExp = 1; mTimeUp = 1;
            end
         end
      end else if (mPause) begin
         if (!p && s) begin
            mPause = 0; mRun = 1;
         end
      end else if (!mExp) begin
         if (!p && s) begin
            if (remSecs == 0) begin
               mExp = 1; mTimeUp = 1;
            end else begin
               mRun = 1;
            end
         end
      end
   endtask

   task automatic compareAll(input string tag);
      checkEq({tag, "_time"}, time_bcd, toBcd(remSecs));
      checkEq({tag, "_running"}, 16'(running), 16'(mRun));
      checkEq({tag, "_timeup"}, 16'(TimeUp), 16'(mTimeUp));
`ifdef SEC_COUNTDOWN_WARN_EN
      checkEq({tag, "_warn"}, 16'(warn),
              16'((mRun || mPause) && remSecs > 0 && remSecs <= int'(WarnSecs)));
`endif
   endtask

   task automatic cycle(input string tag, input bit r, input bit l, input logic [15:0] lt,
                        input bit s, input bit p, input bit t);
      rst = r; load = l; load_time = lt; start = s; pause = p; OneSecTimeout = t;
      @(posedge clk);
      #1;
      modelStep(r, l, lt, s, p, t);
      compareAll(tag);
   endtask

   initial begin
      rst = 1'b1; load = 1'b0; load_time = 16'h0000; start = 1'b0; pause = 1'b0;
      OneSecTimeout = 1'b0;

      cycle("reset", 1, 0, 16'h0, 0, 0, 0);
      checkEq("reset_time_const", time_bcd, 16'h0000);

      // Seconds then minute borrow
      cycle("load0105", 0, 1, 16'h0105, 0, 0, 0);
      cycle("start0105", 0, 0, 16'h0, 1, 0, 0);
      for (int i = 0; i < 6; i++) cycle("tick0105", 0, 0, 16'h0, 0, 0, 1);
      checkEq("borrow_const", time_bcd, 16'h0059);

      // Expiry, then ignored ticks and start
      cycle("load0002", 0, 1, 16'h0002, 0, 0, 0);
      cycle("start0002", 0, 0, 16'h0, 1, 0, 0);
      cycle("tick0001", 0, 0, 16'h0, 0, 0, 1);
      cycle("expire", 0, 0, 16'h0, 0, 0, 1);
      checkEq("expire_pulse_const", 16'(TimeUp), 16'h0001);
      cycle("post_tick", 0, 0, 16'h0, 0, 0, 1);
      cycle("post_start", 0, 0, 16'h0, 1, 0, 1);

      // Pause with coincident tick, paused ticks, resume
      cycle("load1203", 0, 1, 16'h1203, 0, 0, 0);
      cycle("start1203", 0, 0, 16'h0, 1, 0, 0);
      cycle("tick1203", 0, 0, 16'h0, 0, 0, 1);
      cycle("pause_tick", 0, 0, 16'h0, 0, 1, 1);
      for (int i = 0; i < 3; i++) cycle("paused_tick", 0, 0, 16'h0, 0, 0, 1);
      checkEq("paused_hold_const", time_bcd, 16'h1202);
      cycle("resume", 0, 0, 16'h0, 1, 0, 0);
      cycle("tick_resume", 0, 0, 16'h0, 0, 0, 1);

      // Sanitising and start at zero
      cycle("loadFA7C", 0, 1, 16'hFA7C, 0, 0, 0);
      checkEq("sanitise_const", time_bcd, 16'h9959);
      cycle("load0000", 0, 1, 16'h0000, 0, 0, 0);
      cycle("start_zero", 0, 0, 16'h0, 1, 0, 0);
      cycle("zero_after", 0, 0, 16'h0, 0, 0, 0);

      // Reset mid-run
      cycle("load0530", 0, 1, 16'h0530, 0, 0, 0);
      cycle("start0530", 0, 0, 16'h0, 1, 0, 0);
      cycle("rst_run", 1, 0, 16'h0, 0, 0, 1);
      for (int i = 0; i < 3; i++) cycle("tick_after_rst", 0, 0, 16'h0, 0, 0, 1);

      // Warning window
      cycle("load0012", 0, 1, 16'h0012, 0, 0, 0);
      cycle("start0012", 0, 0, 16'h0, 1, 0, 0);
      for (int i = 0; i < 13; i++) cycle("tick_warn", 0, 0, 16'h0, 0, 0, 1);

      // Random phase
      for (int i = 0; i < 4000; i++) begin
         logic [15:0] lt;
         bit          r, l, s, p, t;
         r = ($urandom_range(0, 499) == 0);
         l = ($urandom_range(0, 39) == 0);
         case ($urandom_range(0, 3))
            0:       lt = 16'($urandom);
            1:       lt = {8'h00, 8'($urandom)};
            2:       lt = {12'h000, 4'($urandom)};
            default: lt = {4'h0, 4'($urandom_range(0, 2)), 8'($urandom)};
         endcase
         s = ($urandom_range(0, 7) == 0);
         p = ($urandom_range(0, 19) == 0);
         t = ($urandom_range(0, 2) == 0);
         cycle("random", r, l, lt, s, p, t);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sec_countdown.md
# sec_countdown

Loadable BCD minutes:seconds countdown timer that consumes the single-cycle one-second pulse from the one-second timer stage and counts a game/session time limit down to 00:00. It holds the state machine (idle/run/pause/expired), drives four BCD digits to the seven-segment display stage, and emits a single-cycle `TimeUp` pulse on expiry. Its `running` output drives the one-second timer's `enable`, so the prescaler only advances while the countdown is running.

## Interface
- `WARN_SECS`, default 10: warning threshold in total remaining seconds, valid range 1..59. Used only with `SEC_COUNTDOWN_WARN_EN`.
- `clk` in 1: system clock; the only clock.
- `rst` in 1: synchronous, active-high reset.
- `load` in 1: load `load_time` and enter IDLE.
- `load_time` in 16: BCD time to load, packed {min_tens, min_ones, sec_tens, sec_ones}.
- `start` in 1: level or pulse; IDLE/PAUSE -> RUN.
- `pause` in 1: RUN -> PAUSE.
- `OneSecTimeout` in 1: single-cycle tick from the one-second timer.
- `time_bcd` out 16: current remaining time, same packing as `load_time`.
- `running` out 1: high only in RUN; connects to the one-second timer `enable`.
- `TimeUp` out 1: single-cycle pulse on expiry.
- `warn` out 1: present only with `SEC_COUNTDOWN_WARN_EN`.

## Operation
- States: IDLE, RUN, PAUSE, EXPIRED, 2-bit encoded. Reset puts the block in IDLE.
- Input priority in every state: `rst` > `load` > `pause` > `start` > `OneSecTimeout`.
- `load`, any state:
  - `time_bcd` <= sanitised `load_time`; state -> IDLE.
  - Sanitising: any digit >9 saturates to 9; sec_tens >5 saturates to 5.
- IDLE:
  - `start` with `time_bcd` != 0000 -> RUN.
  - `start` with `time_bcd` == 0000 -> EXPIRED and pulse `TimeUp`.
- RUN:
  - `pause` -> PAUSE.
  - `OneSecTimeout` decrements `time_bcd` by one second.
  - Decrement rules: sec_ones 0 borrows from sec_tens; sec_tens 0 with borrow becomes 5 and borrows from the minutes; min_ones 0 borrows from min_tens.
  - A decrement that reaches 00:00 moves the state to EXPIRED.
- PAUSE: `start` -> RUN. Ticks are ignored.
- EXPIRED:
  - `time_bcd` holds 00:00.
  - `start`, `pause` and ticks are ignored; only `load` or `rst` leaves this state.
- Ticks are ignored in every state except RUN; a count never decrements below 00:00 and never wraps.
- `start` and `pause` asserted together in RUN: pause wins. In PAUSE: stays paused.

## Timing
- All outputs are registered.
- Reset values: `time_bcd`=16'h0000, `running`=0, `TimeUp`=0, `warn`=0, state=IDLE.
- `load` at edge N: `time_bcd` shows the new value after edge N.
- Tick at edge N in RUN: `time_bcd` shows the decremented value after edge N (one-cycle latency).
- Tick taking 00:01 -> 00:00 at edge N:
  - After edge N: `time_bcd`=0000, state EXPIRED, `running`=0, and `TimeUp`=1 for exactly that one cycle.
- `running` follows the state register: it rises the cycle after `start` is sampled and falls the cycle after `pause`, expiry or `load` is sampled.
  - The upstream timer may issue one tick in the cycle `running` is still high after `pause`; that tick is ignored because the state is no longer RUN.
- Tick coincident with `load` or `pause`: the tick is dropped; there is no decrement.
- `rst` mid-run: all outputs return to their reset values on the next edge; a `TimeUp` pulse in flight is cancelled.

## Configuration
- `SEC_COUNTDOWN_WARN_EN` defined:
  - `warn` port exists.
  - `warn`=1 while state is RUN or PAUSE and total remaining seconds (min*60+sec) <= `WARN_SECS` and > 0; otherwise 0.
  - `warn` is registered, so it updates in the same cycle as `time_bcd`. It is 0 in EXPIRED and IDLE.
- `SEC_COUNTDOWN_WARN_EN` undefined: no `warn` port, no comparator logic. All other behaviour is identical.

## Test plan
- Reset, then load 16'h0105 and start, then 5 ticks -> `time_bcd` 0105, 0104, 0103, 0102, 0101, 0100. One more tick -> 0059 (minute borrow).
- Load 16'h0002, start, 2 ticks -> 0001, then 0000. `TimeUp` high exactly one cycle, coincident with 0000. `running` falls. Further ticks and `start` leave 0000, and `TimeUp` stays low.
- Load 16'h1203, start, tick, pause, 3 ticks, start, tick -> 1202 held through the paused ticks, then 1201. Tick coincident with `pause` produces no decrement.
- Load 16'hFA7C -> sanitised to 16'h9959. Load 16'h0000 then start -> EXPIRED with a one-cycle `TimeUp` on the next cycle.
- `rst` asserted in RUN at 0530 -> next cycle `time_bcd`=0, `running`=0, `TimeUp`=0, state IDLE. Subsequent ticks don't change the count.
- With `SEC_COUNTDOWN_WARN_EN` and `WARN_SECS`=10: load 0012, start, ticks -> `warn` 0 at 0011, 1 from 0010 through 0001, 0 at 0000 (EXPIRED).
